// File: rtl/pos_stream_reader_pkg.sv
// ============================================================================
//  Module   : pos_stream_reader_pkg
//  Brief    : Shared sizes and FSM state encoding for the position reader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pos_stream_reader_pkg;

    localparam int ADDR_W = 15;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pos_slot_mux.sv
// ============================================================================
//  Module   : pos_slot_mux
//  Brief    : Selects one address slot from the packed bus; slot 0 is the MSBs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pos_slot_mux
    import pos_stream_reader_pkg::*;
#(
    parameter int SLOT_W    = ADDR_W,
    parameter int NUM_SLOTS = DEPTH,
    parameter int SEL_W     = IDX_W
) (
    input  logic [SLOT_W*NUM_SLOTS-1:0] i_bus,
    input  logic [SEL_W-1:0]            i_idx,
    output logic [SLOT_W-1:0]           o_slot
);

    logic [SLOT_W-1:0] w_slots [NUM_SLOTS];

    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slots
            assign w_slots[g] = i_bus[(NUM_SLOTS-1-g)*SLOT_W +: SLOT_W];
        end
    endgenerate

    assign o_slot = w_slots[i_idx];

endmodule

`default_nettype wire

// File: rtl/pos_stream_reader.sv
// ============================================================================
//  Module   : pos_stream_reader
//  Brief    : Snapshots the packed position bus and streams valid slots out
//             one per valid/ready transfer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pos_stream_reader #(
    parameter int ADDR_W = pos_stream_reader_pkg::ADDR_W,
    parameter int DEPTH  = pos_stream_reader_pkg::DEPTH,
    parameter int CNT_W  = pos_stream_reader_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W*DEPTH-1:0] position,
    input  logic                    isMatching,
    input  logic [CNT_W-1:0]        posCount,
    output logic [ADDR_W-1:0]       outAddr,
    output logic [3:0]              outIndex,
    output logic                    outValid,
    input  logic                    outReady,
    output logic                    busy,
    output logic                    done,
    output logic                    dropLoad
);

    import pos_stream_reader_pkg::*;

    localparam int c_IDX_W = 4;

    state_t                    r_state;
    logic [ADDR_W*DEPTH-1:0]   r_shadow;
    logic [c_IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]          r_cnt;

    logic [CNT_W-1:0]          w_loadCnt;
    logic [c_IDX_W-1:0]        w_nextIdx;
    logic [ADDR_W-1:0]         w_nextAddr;
    logic [ADDR_W-1:0]         w_firstAddr;
    logic                      w_xfer;
    logic                      w_lastXfer;

    assign w_loadCnt   = (posCount > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : posCount;
    assign w_nextIdx   = r_idx + c_IDX_W'(1);
    assign w_xfer      = outValid && outReady;
    assign w_lastXfer  = (CNT_W'(r_idx) == (r_cnt - CNT_W'(1)));
    // The shadow is not yet written on the load edge, so slot 0 comes from the live bus.
    assign w_firstAddr = position[ADDR_W*DEPTH-1 -: ADDR_W];

    pos_slot_mux #(
        .SLOT_W    (ADDR_W),
        .NUM_SLOTS (DEPTH),
        .SEL_W     (c_IDX_W)
    ) u_slotMux (
        .i_bus  (r_shadow),
        .i_idx  (w_nextIdx),
        .o_slot (w_nextAddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            outAddr  <= '0;
            outIndex <= '0;
            outValid <= 1'b0;
            done     <= 1'b0;
            dropLoad <= 1'b0;
        end else begin
            done     <= 1'b0;
            dropLoad <= isMatching && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (isMatching) begin
                        r_shadow <= position;
                        r_cnt    <= w_loadCnt;
                        r_idx    <= '0;
                        outIndex <= '0;
                        outAddr  <= w_firstAddr;
                        if (w_loadCnt != '0) begin
                            r_state  <= S_STREAM;
                            outValid <= 1'b1;
                        end else begin
                            r_state  <= S_DONE;
                            done     <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (w_lastXfer) begin
                            r_state  <= S_DONE;
                            outValid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            r_idx    <= w_nextIdx;
                            outIndex <= w_nextIdx;
                            outAddr  <= w_nextAddr;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (r_state == S_STREAM);

endmodule

`default_nettype wire

// File: tb/tb_pos_stream_reader.sv
// ============================================================================
//  Module   : tb_pos_stream_reader
//  Brief    : Directed and randomized self-checking bench for pos_stream_reader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pos_stream_reader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [239:0] position = '0;
    logic         isMatching = 1'b0;
    logic [4:0]   posCount = '0;
    logic         outReady = 1'b0;
    logic [14:0]  outAddr;
    logic [3:0]   outIndex;
    logic         outValid;
    logic         busy;
    logic         done;
    logic         dropLoad;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    pos_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .position   (position),
        .isMatching (isMatching),
        .posCount   (posCount),
        .outAddr    (outAddr),
        .outIndex   (outIndex),
        .outValid   (outValid),
        .outReady   (outReady),
        .busy       (busy),
        .done       (done),
        .dropLoad   (dropLoad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [239:0] pack(input logic [14:0] s [16]);
        logic [239:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p[(15-i)*15 +: 15] = s[i];
        return p;
    endfunction

    task automatic churnInputs();
        for (int i = 0; i < 16; i++) position[i*15 +: 15] = 15'($urandom());
        posCount = 5'($urandom_range(0, 31));
    endtask

    // Reference: a load yields slots 0..min(pc,16)-1 in order; the bench walks
    // that list, advancing only on cycles where it offered ready.
    // mode 0: ready always high, 1: random ready, 2: ready from pat bits.
    task automatic runLoad(input logic [14:0] s [16], input int pc, input int mode,
                           input logic [7:0] pat, input int dropAt, input bit dropInDone);
        int   n;
        int   k;
        int   cyc;
        logic rdy;
        n   = (pc > 16) ? 16 : pc;
        k   = 0;
        cyc = 0;
        position   = pack(s);
        posCount   = 5'(pc);
        isMatching = 1'b1;
        outReady   = 1'b0;
        step();
        isMatching = 1'b0;
        while (k < n && cyc < 300) begin
            churnInputs();
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = pat[cyc % 8];
            endcase
            outReady   = rdy;
            isMatching = (cyc == dropAt);
            chk("stream_valid", 32'(outValid), 32'd1);
            chk("stream_busy",  32'(busy),     32'd1);
            chk("stream_done",  32'(done),     32'd0);
            chk("stream_index", 32'(outIndex), 32'(k));
            chk("stream_addr",  32'(outAddr),  32'(s[k]));
            chk("stream_drop",  32'(dropLoad), 32'((dropAt >= 0) && (cyc == dropAt + 1)));
            step();
            if (rdy) k++;
            cyc++;
        end
        if (k < n) chk("stream_timeout", 32'(k), 32'(n));
        outReady   = 1'b0;
        isMatching = dropInDone;
        chk("done_pulse", 32'(done),     32'd1);
        chk("done_valid", 32'(outValid), 32'd0);
        chk("done_busy",  32'(busy),     32'd0);
        step();
        isMatching = 1'b0;
        chk("post_done",  32'(done),     32'd0);
        chk("post_busy",  32'(busy),     32'd0);
        chk("post_valid", 32'(outValid), 32'd0);
        chk("post_drop",  32'(dropLoad), 32'(dropInDone));
        step();
    endtask

    initial begin
        logic [14:0] s [16];

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(outValid), 32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_drop",  32'(dropLoad), 32'd0);
        chk("rst_addr",  32'(outAddr),  32'd0);
        chk("rst_index", 32'(outIndex), 32'd0);
        rst_n = 1'b1;
        step();

        // Full 16-entry ramp, ready held high
        for (int i = 0; i < 16; i++) s[i] = 15'(i + 1);
        runLoad(s, 16, 0, 8'h00, -1, 1'b0);

        // Three entries with ready pattern 1,0,0,1,1
        for (int i = 0; i < 16; i++) s[i] = 15'($urandom());
        runLoad(s, 3, 2, 8'b0001_1001, -1, 1'b0);

        // Empty load
        runLoad(s, 0, 0, 8'h00, -1, 1'b0);

        // Count above DEPTH clamps to 16, random ready
        for (int i = 0; i < 16; i++) s[i] = 15'($urandom());
        runLoad(s, 20, 1, 8'h00, -1, 1'b0);

        // Load attempts mid-stream and in DONE are dropped
        for (int i = 0; i < 16; i++) s[i] = 15'($urandom());
        runLoad(s, 10, 0, 8'h00, 4, 1'b1);

        // Reset mid-stream after 3 of 8 transfers
        for (int i = 0; i < 16; i++) s[i] = 15'($urandom());
        position   = pack(s);
        posCount   = 5'd8;
        isMatching = 1'b1;
        outReady   = 1'b1;
        step();
        isMatching = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_index", 32'(outIndex), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(outValid), 32'd0);
        chk("mid_rst_busy",  32'(busy),     32'd0);
        chk("mid_rst_done",  32'(done),     32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("after_rst_done", 32'(done), 32'd0);
        chk("after_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) s[i] = 15'($urandom());
        runLoad(s, 5, 0, 8'h00, -1, 1'b0);

        // Random loads
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) s[i] = 15'($urandom());
            runLoad(s, $urandom_range(0, 31), 1, 8'h00, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
